// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Requests instruction words from a single-outstanding-request memory,
// holds each returned word (with its address) until the decoder takes it,
// and redirects the fetch stream on branch/jump requests. A level-sensitive
// halt parks the unit after the next decoder transfer until a redirect
// arrives.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   imem_req, imem_addr   : memory read request and word address
//   imem_ack, imem_rdata  : single-cycle data-valid and returned word
//   inst, inst_pc         : instruction and its fetch address to the decoder
//   inst_valid/inst_ready : decoder handshake
//   redirect_*            : branch/jump request (absolute or base+offset)
//   halt, halted          : halt request level and parked indication
//   fetch_count           : number of completed decoder transfers (wraps)
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst_pc,
  input  logic        redirect_valid,
  input  logic        redirect_rel,
  input  logic [15:0] redirect_base,
  input  logic [10:0] redirect_off,
  input  logic        halt,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_VALID  = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  // Redirect target parked while the abandoned request is drained; pc_q
  // keeps the old address so imem_addr stays stable until the ack.
  logic [15:0] tgt_q, tgt_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic [15:0] count_q, count_d;
  logic [15:0] target_s;
  logic        xfer_s;

  // Redirect target: absolute base, or base plus sign-extended offset.
  always_comb begin
    if (redirect_rel) begin
      target_s = redirect_base + {{5{redirect_off[10]}}, redirect_off};
    end else begin
      target_s = redirect_base;
    end
  end

  assign xfer_s = (state_q == S_VALID) && inst_ready;

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    count_d   = count_q;
    case (state_q)
      S_FETCH: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            // Data for the old stream is dropped; restart at once.
            pc_d    = target_s;
            state_d = S_FETCH;
          end else begin
            tgt_d   = target_s;
            state_d = S_DRAIN;
          end
        end else if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          pc_d      = pc_q + 16'd1;
          state_d   = S_VALID;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_VALID: begin
        // A transfer in the redirect cycle still completes and is counted.
        if (xfer_s) begin
          count_d = count_q + 16'd1;
        end else begin
          count_d = count_q;
        end
        if (redirect_valid) begin
          pc_d    = target_s;
          state_d = S_FETCH;
        end else if (xfer_s) begin
          state_d = halt ? S_HALTED : S_FETCH;
        end else begin
          state_d = S_VALID;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          tgt_d = target_s;
        end else begin
          tgt_d = tgt_q;
        end
        if (imem_ack) begin
          pc_d    = redirect_valid ? target_s : tgt_q;
          state_d = S_FETCH;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_HALTED: begin
        if (redirect_valid) begin
          pc_d    = target_s;
          state_d = S_FETCH;
        end else begin
          state_d = S_HALTED;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= 16'h0000;
      tgt_q     <= 16'h0000;
      inst_q    <= 16'h0000;
      inst_pc_q <= 16'h0000;
      count_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      count_q   <= count_d;
    end
  end

  // Control outputs decode the registered state; they are forced low
  // while reset is held so nothing is requested or presented.
  assign imem_req    = ~reset & ((state_q == S_FETCH) | (state_q == S_DRAIN));
  assign inst_valid  = ~reset & (state_q == S_VALID);
  assign halted      = ~reset & (state_q == S_HALTED);
  assign imem_addr   = pc_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a per-cycle vector table, hand-written
// multi-cycle corner sequences, and a randomized run against a behavioural
// model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_pc;
  logic        redirect_valid;
  logic        redirect_rel;
  logic [15:0] redirect_base;
  logic [10:0] redirect_off;
  logic        halt;
  logic        halted;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_rel(redirect_rel),
    .redirect_base(redirect_base), .redirect_off(redirect_off),
    .halt(halt), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic [15:0] rdata;
    logic        rdy;
    logic        redir;
    logic        rel;
    logic [15:0] base;
    logic [10:0] off;
    logic        hlt_in;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] inst;
    logic [15:0] ipc;
    logic        hlt;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic clr();
    imem_ack       = 1'b0;
    imem_rdata     = 16'h0000;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_rel   = 1'b0;
    redirect_base  = 16'h0000;
    redirect_off   = 11'h000;
    halt           = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Behavioural model state: the fetch pointer, whether a word is being
  // held for the decoder, whether the unit is parked, and whether the
  // outstanding memory reply belongs to an abandoned stream.
  logic [15:0] m_pc, m_pend, m_inst, m_ipc, m_cnt;
  logic        m_have, m_park, m_discard;

  task automatic model_step();
    logic [15:0] t;
    t = redirect_rel ? redirect_base + {{5{redirect_off[10]}}, redirect_off} : redirect_base;
    if (reset) begin
      m_pc = 16'h0000; m_pend = 16'h0000; m_inst = 16'h0000; m_ipc = 16'h0000;
      m_cnt = 16'h0000; m_have = 1'b0; m_park = 1'b0; m_discard = 1'b0;
    end else if (m_park) begin
      if (redirect_valid) begin m_park = 1'b0; m_pc = t; end
    end else if (m_have) begin
      if (inst_ready) m_cnt = m_cnt + 16'd1;
      if (redirect_valid) begin m_have = 1'b0; m_pc = t; end
      else if (inst_ready) begin m_have = 1'b0; m_park = halt; end
    end else if (m_discard) begin
      if (redirect_valid) m_pend = t;
      if (imem_ack) begin m_discard = 1'b0; m_pc = m_pend; end
    end else begin
      if (redirect_valid) begin
        if (imem_ack) m_pc = t;
        else begin m_discard = 1'b1; m_pend = t; end
      end else if (imem_ack) begin
        m_inst = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 16'd1; m_have = 1'b1;
      end
    end
  endtask

  initial begin
    // rst ack rdata rdy redir rel base off halt | req addr vld inst ipc hlt cnt
    vt[0]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000};
    vt[1]  = '{1'b0,1'b1,16'hA5A5,1'b0,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b1,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000};
    vt[2]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b0,16'h0000,1'b1,16'hA5A5,16'h0000,1'b0,16'h0000};
    vt[3]  = '{1'b0,1'b1,16'hA5A4,1'b1,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b1,16'h0001,1'b0,16'h0000,16'h0000,1'b0,16'h0001};
    vt[4]  = '{1'b0,1'b1,16'h0000,1'b1,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b0,16'h0000,1'b1,16'hA5A4,16'h0001,1'b0,16'h0001};
    vt[5]  = '{1'b0,1'b1,16'hA5A7,1'b1,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b1,16'h0002,1'b0,16'h0000,16'h0000,1'b0,16'h0002};
    vt[6]  = '{1'b0,1'b1,16'h0000,1'b1,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b0,16'h0000,1'b1,16'hA5A7,16'h0002,1'b0,16'h0002};
    vt[7]  = '{1'b0,1'b1,16'hA5A6,1'b1,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b1,16'h0003,1'b0,16'h0000,16'h0000,1'b0,16'h0003};
    vt[8]  = '{1'b0,1'b1,16'h0000,1'b1,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b0,16'h0000,1'b1,16'hA5A6,16'h0003,1'b0,16'h0003};
    vt[9]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b1,16'h0004,1'b0,16'h0000,16'h0000,1'b0,16'h0004};
    vt[10] = '{1'b0,1'b1,16'h1234,1'b0,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b1,16'h0004,1'b0,16'h0000,16'h0000,1'b0,16'h0004};
    vt[11] = '{1'b0,1'b0,16'h0000,1'b0,1'b1,1'b1,16'h0010,11'h7FC,1'b0, 1'b0,16'h0000,1'b1,16'h1234,16'h0004,1'b0,16'h0004};
    vt[12] = '{1'b0,1'b0,16'h0000,1'b0,1'b1,1'b0,16'hFFFF,11'h000,1'b0, 1'b1,16'h000C,1'b0,16'h0000,16'h0000,1'b0,16'h0004};
    vt[13] = '{1'b0,1'b1,16'h0BAD,1'b0,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b1,16'h000C,1'b0,16'h0000,16'h0000,1'b0,16'h0004};
    vt[14] = '{1'b0,1'b1,16'hBEEF,1'b0,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b1,16'hFFFF,1'b0,16'h0000,16'h0000,1'b0,16'h0004};
    vt[15] = '{1'b0,1'b0,16'h0000,1'b1,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b0,16'h0000,1'b1,16'hBEEF,16'hFFFF,1'b0,16'h0004};
    vt[16] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000,11'h000,1'b0, 1'b1,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0005};

    clr();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table: each row is one cycle of inputs plus expected outputs.
    for (int i = 0; i < NV; i++) begin
      reset = vt[i].rst; imem_ack = vt[i].ack; imem_rdata = vt[i].rdata;
      inst_ready = vt[i].rdy; redirect_valid = vt[i].redir; redirect_rel = vt[i].rel;
      redirect_base = vt[i].base; redirect_off = vt[i].off; halt = vt[i].hlt_in;
      #1;
      chk1($sformatf("vec%0d_req", i), imem_req, vt[i].req);
      chk1($sformatf("vec%0d_valid", i), inst_valid, vt[i].vld);
      chk1($sformatf("vec%0d_halted", i), halted, vt[i].hlt);
      chk($sformatf("vec%0d_count", i), fetch_count, vt[i].cnt);
      if (vt[i].req) chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].addr);
      if (vt[i].vld || vt[i].rst) begin
        chk($sformatf("vec%0d_inst", i), inst, vt[i].inst);
        chk($sformatf("vec%0d_pc", i), inst_pc, vt[i].ipc);
      end
      @(negedge clk);
    end

    // Backpressure: five stalled cycles in VALID, transfer on first ready.
    do_reset();
    imem_ack = 1'b1; imem_rdata = 16'h1111;
    #1 chk("bp_addr0", imem_addr, 16'h0000);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 16'h2222; inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk1("bp_valid", inst_valid, 1'b1);
      chk("bp_inst", inst, 16'h1111);
      chk("bp_pc", inst_pc, 16'h0000);
      chk1("bp_req", imem_req, 1'b0);
      chk("bp_count", fetch_count, 16'h0000);
      @(negedge clk);
    end
    inst_ready = 1'b1; imem_ack = 1'b0;
    #1 chk1("bp_valid_last", inst_valid, 1'b1);
    @(negedge clk);
    clr();
    #1;
    chk1("bp_after_valid", inst_valid, 1'b0);
    chk("bp_after_count", fetch_count, 16'h0001);
    chk("bp_after_addr", imem_addr, 16'h0001);

    // Redirect during a 3-wait-state fetch of 0x0005.
    do_reset();
    imem_ack = 1'b1; imem_rdata = 16'h0BAD; redirect_valid = 1'b1; redirect_base = 16'h0005;
    @(negedge clk);
    clr();
    redirect_valid = 1'b1; redirect_base = 16'h0100;
    #1 chk("ws_addr_first", imem_addr, 16'h0005);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      clr();
      imem_ack = (k == 2);
      imem_rdata = 16'hDEAD;
      #1;
      chk1("ws_req", imem_req, 1'b1);
      chk("ws_addr", imem_addr, 16'h0005);
      chk1("ws_valid", inst_valid, 1'b0);
      @(negedge clk);
    end
    clr();
    imem_ack = 1'b1; imem_rdata = 16'h5555;
    #1;
    chk1("ws_valid_after", inst_valid, 1'b0);
    chk("ws_addr_new", imem_addr, 16'h0100);
    @(negedge clk);
    clr();
    #1;
    chk("ws_inst", inst, 16'h5555);
    chk("ws_pc", inst_pc, 16'h0100);

    // Halt before transfer of 0x0002, stay parked, resume on redirect.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      clr(); imem_ack = 1'b1; imem_rdata = 16'h00F0;
      @(negedge clk);
      clr(); inst_ready = 1'b1;
      @(negedge clk);
    end
    clr(); imem_ack = 1'b1; imem_rdata = 16'h2222;
    @(negedge clk);
    clr(); halt = 1'b1; inst_ready = 1'b1;
    #1 chk("halt_pc", inst_pc, 16'h0002);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      clr(); imem_ack = 1'b1;
      #1;
      chk1("halt_halted", halted, 1'b1);
      chk1("halt_req", imem_req, 1'b0);
      @(negedge clk);
    end
    clr(); halt = 1'b1; redirect_valid = 1'b1; redirect_base = 16'h0040;
    @(negedge clk);
    clr(); halt = 1'b1;
    #1;
    chk1("halt_exit", halted, 1'b0);
    chk1("halt_exit_req", imem_req, 1'b1);
    chk("halt_exit_addr", imem_addr, 16'h0040);
    chk("halt_count", fetch_count, 16'h0003);

    // Reset while draining, with a late ack during reset.
    do_reset();
    imem_ack = 1'b1; imem_rdata = 16'h7777;
    @(negedge clk);
    clr(); inst_ready = 1'b1;
    @(negedge clk);
    clr(); redirect_valid = 1'b1; redirect_base = 16'h0123;
    @(negedge clk);
    clr();
    #1 chk("rd_drain_addr", imem_addr, 16'h0001);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h9999;
    #1;
    chk1("rd_req", imem_req, 1'b0);
    chk1("rd_valid", inst_valid, 1'b0);
    chk1("rd_halted", halted, 1'b0);
    @(negedge clk);
    #1;
    chk("rd_inst", inst, 16'h0000);
    chk("rd_pc", inst_pc, 16'h0000);
    chk("rd_count", fetch_count, 16'h0000);
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h4444;
    #1;
    chk1("rd_first_req", imem_req, 1'b1);
    chk("rd_first_addr", imem_addr, 16'h0000);
    @(negedge clk);
    clr();
    #1;
    chk("rd_first_inst", inst, 16'h4444);
    chk("rd_first_pc", inst_pc, 16'h0000);

    // Randomized run against the behavioural model.
    do_reset();
    m_pc = 16'h0000; m_pend = 16'h0000; m_inst = 16'h0000; m_ipc = 16'h0000;
    m_cnt = 16'h0000; m_have = 1'b0; m_park = 1'b0; m_discard = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      imem_ack       = $urandom_range(0, 1) == 1;
      imem_rdata     = 16'($urandom);
      inst_ready     = $urandom_range(0, 2) != 0;
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_rel   = $urandom_range(0, 1) == 1;
      redirect_base  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      redirect_off   = 11'($urandom);
      halt           = ($urandom_range(0, 5) == 0);
      #1;
      chk1("rnd_req", imem_req, ~reset & ~m_have & ~m_park);
      if (!reset && !m_have && !m_park) chk("rnd_addr", imem_addr, m_pc);
      chk1("rnd_valid", inst_valid, ~reset & m_have);
      chk1("rnd_halted", halted, ~reset & m_park);
      chk("rnd_inst", inst, m_inst);
      chk("rnd_pc", inst_pc, m_ipc);
      chk("rnd_count", fetch_count, m_cnt);
      model_step();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising clk.
REQ-003 imem_req  out  1  instruction-memory read request.
REQ-004 imem_addr  out  16  word address of the request; held stable while imem_req=1 and imem_ack=0.
REQ-005 imem_ack  in  1  single-cycle data-valid from memory; ignored when imem_req=0.
REQ-006 imem_rdata  in  16  instruction word; valid only when imem_ack=1.
REQ-007 inst  out  16  instruction to decoder.
REQ-008 inst_valid  out  1  inst and inst_pc valid.
REQ-009 inst_ready  in  1  decoder accepts inst; a transfer occurs when inst_valid=1 and inst_ready=1 in the same cycle.
REQ-010 inst_pc  out  16  address inst was fetched from.
REQ-011 redirect_valid  in  1  branch/jump request, one cycle.
REQ-012 redirect_rel  in  1  1 = relative target, 0 = absolute.
REQ-013 redirect_base  in  16  absolute target, or base PC when relative.
REQ-014 redirect_off  in  11  signed offset, two's complement, used when redirect_rel=1.
REQ-015 halt  in  1  level; stop fetching after the current transfer.
REQ-016 halted  out  1  state is HALTED.
REQ-017 fetch_count  out  16  count of completed decoder transfers.

Function
REQ-018 Target = redirect_rel ? redirect_base + sign_extend16(redirect_off) : redirect_base, modulo 2^16.
REQ-019 States: FETCH, VALID, DRAIN, HALTED; imem_req=1 in FETCH and DRAIN only; inst_valid=1 in VALID only; halted=1 in HALTED only.
REQ-020 FETCH: imem_addr=pc; on imem_ack capture inst<=imem_rdata, inst_pc<=pc, pc<=pc+1 (wrapping 0xFFFF->0x0000), then go to VALID.
REQ-021 VALID: inst, inst_pc held constant until transfer; on transfer fetch_count+1 (wrapping), then go to HALTED if halt=1, else FETCH.
REQ-022 Minimum latency: imem_ack in cycle N gives inst_valid=1 in cycle N+1; with zero-wait memory and inst_ready tied 1, one instruction is delivered every 2 cycles.
REQ-023 redirect_valid has priority over every other event in every state: pc<=target.
REQ-024 redirect_valid in FETCH with imem_ack=0: go to DRAIN; keep imem_req=1 at the old address; discard data on ack; then go to FETCH at target.
REQ-025 redirect_valid in FETCH with imem_ack=1: discard data; go to FETCH at target next cycle; no DRAIN.
REQ-026 redirect_valid in VALID: inst_valid=0 next cycle; go to FETCH at target; if inst_ready=1 in the same cycle, the transfer completes and is counted.
REQ-027 redirect_valid in DRAIN: target is replaced by the newest target; the drain continues.
REQ-028 redirect_valid in HALTED: go to FETCH at target; halt is ignored for this exit.
REQ-029 halt in FETCH or DRAIN has no effect until the next transfer out of VALID.
REQ-030 HALTED is left only by redirect_valid or reset.

Reset
REQ-031 Reset values: pc=0x0000, state FETCH, inst=0x0000, inst_pc=0x0000, fetch_count=0x0000.
REQ-032 While reset=1, imem_req=0, inst_valid=0 and halted=0; imem_req=1 with imem_addr=0x0000 in the first cycle after reset deasserts.
REQ-033 Reset mid-operation (any state, including DRAIN) abandons the pending memory access; a late imem_ack arriving while reset=1 is ignored.

Verification
REQ-034 Zero-wait memory returning mem[a]=a^16'hA5A5, inst_ready=1 -> inst_pc 0,1,2,3 with inst 0xA5A5,0xA5A4,0xA5A7,0xA5A6; fetch_count=4 after 8 cycles.
REQ-035 Backpressure: inst_ready=0 for 5 cycles while in VALID -> inst and inst_pc stable, imem_req=0, fetch_count unchanged; the transfer occurs on the first cycle inst_ready=1.
REQ-036 Relative redirect base=0x0010, off=11'h7FC (-4) in VALID -> next imem_addr=0x000C; absolute base=0xFFFF, then sequential fetch -> 0xFFFF followed by 0x0000.
REQ-037 Redirect during a 3-wait-state fetch of 0x0005 to absolute 0x0100 -> imem_addr stays 0x0005 until ack, that data is never presented, next request is 0x0100.
REQ-038 halt=1 before transfer of inst_pc=0x0002 -> halted=1 the next cycle, imem_req=0 for 10 cycles; redirect to 0x0040 -> fetch resumes at 0x0040.
REQ-039 Reset asserted in DRAIN with imem_ack arriving during reset -> all outputs at reset values; first request after reset is to 0x0000.
